// File: rtl/whirlpool_theta_sigma_if.sv
// Handshake bundle for the Whirlpool theta+sigma stage: an upstream block
// (state + round key) and a downstream result, both valid/ready.
interface whirlpool_theta_sigma_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_data;
   logic [511:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_data;

   // Producer of blocks and consumer of results (testbench / surrounding round).
   modport master (
      output in_valid, in_data, in_key, out_ready,
      input  in_ready, out_valid, out_data
   );

   // The theta+sigma stage itself.
   modport slave (
      input  in_valid, in_data, in_key, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/whirlpool_theta_sigma.sv
// Iterative MixRows (theta) + AddRoundKey (sigma) for the Whirlpool W round.
// ROWS_PER_CYCLE rows of the 8x8 byte state are mixed per clock, in place in
// the work register; the finished block is copied to a separate output
// register so partially processed rows never appear on out_data.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | empty, in_ready=1, waiting for a block
// S_BUSY | mixing rows row_idx..row_idx+RPC-1 each cycle, in_ready=0
// S_DONE | result held on out_data; in_ready follows out_ready (back-to-back)
module whirlpool_theta_sigma #(
   parameter int ROWS_PER_CYCLE = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   whirlpool_theta_sigma_if.slave  bus
);

   localparam int         RPC      = ROWS_PER_CYCLE;
   localparam logic [2:0] ROW_STEP = 3'(RPC);
   localparam logic [2:0] LAST_IDX = 3'(8 - RPC);

   generate
      if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
         $error("whirlpool_theta_sigma: ROWS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t       state_q, state_d;
   logic [2:0]   row_idx_q;
   logic [511:0] work_q, key_q, out_data_q;
   logic [511:0] work_next;
   logic         accept, last_grp;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1 (0x11D).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
   endfunction

   // One row of the circulant C = circ(01,01,04,01,08,05,02,09):
   // b[j] = XOR_k a[k] * c[(j-k) mod 8]. Only x1/x2/x4/x8 multiples are needed.
   function automatic logic [63:0] mix_row(input logic [63:0] a);
      logic [7:0]  x1 [8];
      logic [7:0]  x2 [8];
      logic [7:0]  x4 [8];
      logic [7:0]  x8 [8];
      logic [7:0]  acc;
      logic [63:0] b;
      b = '0;
      for (int k = 0; k < 8; k++) begin
         x1[k] = a[63-8*k -: 8];
         x2[k] = xtime(x1[k]);
         x4[k] = xtime(x2[k]);
         x8[k] = xtime(x4[k]);
      end
      for (int j = 0; j < 8; j++) begin
         acc = 8'h00;
         for (int k = 0; k < 8; k++) begin
            case ((j - k + 8) % 8)
               2:       acc = acc ^ x4[k];
               4:       acc = acc ^ x8[k];
               5:       acc = acc ^ x4[k] ^ x1[k];
               6:       acc = acc ^ x2[k];
               7:       acc = acc ^ x8[k] ^ x1[k];
               default: acc = acc ^ x1[k];
            endcase
         end
         b[63-8*j -: 8] = acc;
      end
      return b;
   endfunction

   assign accept   = bus.in_valid & bus.in_ready;
   assign last_grp = (row_idx_q == LAST_IDX);

   // Replace the current group of rows with mixed ^ key; other rows pass through.
   always_comb begin
      logic [2:0] row;
      int         base;
      row       = '0;
      base      = 0;
      work_next = work_q;
      for (int r = 0; r < RPC; r++) begin
         row  = row_idx_q + 3'(r);
         base = 511 - 64 * int'(row);
         work_next[base -: 64] = mix_row(work_q[base -: 64]) ^ key_q[base -: 64];
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; DONE hands straight to BUSY when a new block is taken.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_BUSY;
         S_BUSY: if (last_grp) state_d = S_DONE;
         S_DONE: begin
            if (accept)             state_d = S_BUSY;
            else if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs; both forced low while reset is asserted.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IDLE:  bus.in_ready = 1'b1;
            S_DONE: begin
               bus.in_ready  = bus.out_ready;
               bus.out_valid = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath: latch a new block, iterate over row groups, publish on completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         work_q     <= '0;
         key_q      <= '0;
         row_idx_q  <= '0;
         out_data_q <= '0;
      end else if (accept) begin
         work_q    <= bus.in_data;
         key_q     <= bus.in_key;
         row_idx_q <= '0;
      end else if (state_q == S_BUSY) begin
         work_q    <= work_next;
         row_idx_q <= row_idx_q + ROW_STEP;
         if (last_grp) out_data_q <= work_next;
      end
   end

   assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_whirlpool_theta_sigma.sv
// Directed + reference-model bench for whirlpool_theta_sigma at ROWS_PER_CYCLE=2.
module tb_whirlpool_theta_sigma;

   localparam int LAT = 4;
   localparam logic [7:0] CC [8] = '{8'h01, 8'h01, 8'h04, 8'h01, 8'h08, 8'h05, 8'h02, 8'h09};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   whirlpool_theta_sigma_if bus();

   whirlpool_theta_sigma #(.ROWS_PER_CYCLE(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string        name;
      logic [511:0] d;
      logic [511:0] k;
      logic [511:0] e;
   } vec_t;

   vec_t vecs [10];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shift-and-add GF(2^8) multiply, poly 0x11D.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = {aa[6:0], 1'b0};
         if (hi) aa = aa ^ 8'h1D;
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [511:0] golden(input logic [511:0] d, input logic [511:0] k);
      logic [511:0] o;
      logic [7:0]   acc;
      o = '0;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            acc = 8'h00;
            for (int m = 0; m < 8; m++)
               acc = acc ^ gf_mul(d[511-64*i-8*m -: 8], CC[(j - m + 8) % 8]);
            o[511-64*i-8*j -: 8] = acc ^ k[511-64*i-8*j -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic send(input string name, input logic [511:0] d, input logic [511:0] k);
      int w;
      w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_key   = k;
      while (!bus.in_ready && w < 20) begin
         tick();
         w++;
      end
      check({name, "_accept_wait"}, 512'(w < 20), 512'(1));
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = rand512();
      bus.in_key   = rand512();
   endtask

   task automatic wait_out(output int cnt);
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
         tick();
         cnt++;
      end
   endtask

   task automatic run_block(input string name, input logic [511:0] d,
                            input logic [511:0] k, input logic [511:0] e);
      int cnt;
      send(name, d, k);
      wait_out(cnt);
      check({name, "_latency"}, 512'(cnt), 512'(LAT));
      check(name, bus.out_data, e);
      tick();
   endtask

   task automatic set_vec(input int i, input string n, input logic [511:0] d,
                          input logic [511:0] k, input logic [511:0] e);
      vecs[i].name = n;
      vecs[i].d    = d;
      vecs[i].k    = k;
      vecs[i].e    = e;
   endtask

   initial begin
      logic [511:0] da, ka, db, kb, dc, kc;
      int           cnt;
      logic         any_valid;

      set_vec(0, "col0_one",  {8{64'h0100000000000000}}, '0, {8{64'h0101040108050209}});
      set_vec(1, "col1_one",  {8{64'h0001000000000000}}, '0, {8{64'h0901010401080502}});
      set_vec(2, "all80_keyff", {64{8'h80}}, {64{8'hFF}}, {64{8'h62}});
      set_vec(3, "all01",     {64{8'h01}}, '0, {64{8'h03}});
      set_vec(4, "key_only",  '0, {8{64'h0011223344556677}}, {8{64'h0011223344556677}});
      set_vec(5, "col0_80",   {8{64'h8000000000000000}}, '0, {8{64'h80803A8074BA1DF4}});
      set_vec(6, "col0_02",   {8{64'h0200000000000000}}, '0, {8{64'h02020802100A0412}});
      set_vec(7, "row0_only", {64'h0100000000000000, 448'h0}, '0, {64'h0101040108050209, 448'h0});
      set_vec(8, "row7_only", {448'h0, 64'h0001000000000000}, '0, {448'h0, 64'h0901010401080502});
      set_vec(9, "col0_keyff", {8{64'h0100000000000000}}, {64{8'hFF}}, {8{64'hFEFEFBFEF7FAFDF6}});

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_key    = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready",  512'(bus.in_ready),  512'(0));
      check("rst_out_valid", 512'(bus.out_valid), 512'(0));
      check("rst_out_data",  bus.out_data, '0);
      reset = 1'b0;
      #1;
      check("rel_in_ready", 512'(bus.in_ready), 512'(1));

      for (int i = 0; i < 10; i++)
         run_block(vecs[i].name, vecs[i].d, vecs[i].k, vecs[i].e);

      for (int i = 0; i < 12; i++) begin
         da = rand512();
         ka = rand512();
         run_block($sformatf("rand%0d", i), da, ka, golden(da, ka));
      end

      // Stall in DONE, then same-edge handoff to the next block.
      da = rand512();
      ka = rand512();
      db = rand512();
      kb = rand512();
      bus.out_ready = 1'b0;
      send("stall_a", da, ka);
      wait_out(cnt);
      check("stall_a_latency", 512'(cnt), 512'(LAT));
      bus.in_valid = 1'b1;
      bus.in_data  = db;
      bus.in_key   = kb;
      for (int i = 0; i < 5; i++) begin
         check("stall_in_ready", 512'(bus.in_ready), 512'(0));
         tick();
         check("stall_out_valid", 512'(bus.out_valid), 512'(1));
         check("stall_out_data", bus.out_data, golden(da, ka));
      end
      bus.out_ready = 1'b1;
      #1;
      check("handoff_in_ready", 512'(bus.in_ready), 512'(1));
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = rand512();
      bus.in_key   = rand512();
      check("handoff_out_valid", 512'(bus.out_valid), 512'(0));
      check("handoff_hold_data", bus.out_data, golden(da, ka));
      wait_out(cnt);
      check("handoff_b_latency", 512'(cnt), 512'(LAT));
      check("handoff_b_data", bus.out_data, golden(db, kb));
      tick();
      check("handoff_no_dup", 512'(bus.out_valid), 512'(0));

      // Reset two cycles into BUSY discards the block.
      dc = rand512();
      kc = rand512();
      send("rst_busy", dc, kc);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("rstbusy_in_ready",  512'(bus.in_ready),  512'(0));
      check("rstbusy_out_valid", 512'(bus.out_valid), 512'(0));
      check("rstbusy_out_data",  bus.out_data, '0);
      reset = 1'b0;
      #1;
      check("rstbusy_rel_ready", 512'(bus.in_ready), 512'(1));
      any_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         any_valid = any_valid | bus.out_valid;
      end
      check("rstbusy_no_pulse", 512'(any_valid), 512'(0));
      run_block("after_rst", dc, kc, golden(dc, kc));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
